// File: rtl/count_pwm_pkg.sv
// count_pwm_pkg: shared widths, count ceiling and FSM state encoding for the PWM slice
package count_pwm_pkg;
  localparam int CNT_W = 4;
  localparam int PCNT_W = 8;
  localparam int CNT_MAX = 15;
  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
endpackage

// File: rtl/count_pwm_wrap_det.sv
// count_pwm_wrap_det: registers the upstream count, flags its 15->0 wrap and any out-of-sequence step
module count_pwm_wrap_det #(
  parameter int CNT_W = count_pwm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] count_in,
  input  logic             check,
  output logic             wrap,
  output logic             seq_bad
);
  import count_pwm_pkg::*;
  logic [CNT_W-1:0] count_q;
  // previous count; cleared by reset so the first cycle after release cannot look like a wrap
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) count_q <= '0;
    else count_q <= count_in;
  // wrap is the top-to-zero step; a bad step is anything other than +1 while checking is on
  always_comb begin
    wrap = count_q == CNT_W'(CNT_MAX) && count_in == '0;
    seq_bad = check && count_in != count_q + CNT_W'(1);
  end
endmodule

// File: rtl/counter_4bit.sv
// counter_4bit: free-running 4-bit up-counter with a synchronous load to inject sequence breaks
module counter_4bit (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q
);
  // count up every cycle, or jump to d when ld is set
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else q <= ld ? d : q + 4'd1;
endmodule

// File: rtl/count_pwm.sv
// count_pwm: PWM generator locked to an upstream 4-bit count, with duty handshake and period counter
module count_pwm #(
  parameter int CNT_W = count_pwm_pkg::CNT_W,
  parameter int PCNT_W = count_pwm_pkg::PCNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              en,
  input  logic [CNT_W-1:0]  duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_tick,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              seq_err
);
  import count_pwm_pkg::*;
  state_t state, state_nxt;
  logic wrap, seq_bad, pending, in_run, live, xfer;
  logic [CNT_W-1:0] duty_active, duty_pend;

  count_pwm_wrap_det #(.CNT_W(CNT_W)) u_wrap_det (
    .clk      (clk),
    .rstn     (rstn),
    .count_in (count_in),
    .check    (in_run),
    .wrap     (wrap),
    .seq_bad  (seq_bad)
  );

  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;

  // next state: losing enable overrides everything, otherwise wait for a wrap to start running
  always_comb
    state_nxt = !en ? IDLE :
                state == IDLE ? SYNC :
                (state == SYNC && wrap) ? RUN : state;

  // state decode: live marks a wrap that counts as a period boundary
  always_comb begin
    in_run = en && state == RUN;
    live = en && state != IDLE && wrap;
    duty_ready = !pending;
    xfer = duty_valid && duty_ready;
  end

  // duty handshake: a transfer on a boundary bypasses the pending slot, otherwise it waits for one
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      duty_active <= '0;
      duty_pend <= '0;
      pending <= 1'b0;
    end else if (live && xfer) begin
      duty_active <= duty_in;
    end else if (live && pending) begin
      duty_active <= duty_pend;
      pending <= 1'b0;
    end else if (xfer) begin
      duty_pend <= duty_in;
      pending <= 1'b1;
    end

  // PWM compare, period bookkeeping and the sticky sequence error, cleared whenever idling
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pwm_out <= 1'b0;
      period_tick <= 1'b0;
      period_cnt <= '0;
      seq_err <= 1'b0;
    end else begin
      pwm_out <= in_run && count_in < duty_active;
      period_tick <= live;
      period_cnt <= period_cnt + PCNT_W'(live);
      seq_err <= (!en || state == IDLE) ? 1'b0 : seq_err || seq_bad;
    end
endmodule

// File: tb/tb_count_pwm.sv
// tb_count_pwm: directed checks of count_pwm driven by a counter_4bit stimulus source
module tb_count_pwm;
  logic clk = 1'b0, rstn, en, duty_valid, duty_ready, pwm_out, period_tick, seq_err, ld;
  logic [3:0] duty_in, ld_val, ctr, m_q;
  logic [7:0] period_cnt, m_cnt;
  logic m_on;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  counter_4bit u_ctr (.clk(clk), .rstn(rstn), .ld(ld), .d(ld_val), .q(ctr));

  count_pwm u_dut (
    .clk(clk), .rstn(rstn), .count_in(ctr), .en(en), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm_out(pwm_out),
    .period_tick(period_tick), .period_cnt(period_cnt), .seq_err(seq_err)
  );

  // reference period count: a wrap counts when enabled and not coming out of idle
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_q <= '0;
      m_on <= 1'b0;
      m_cnt <= '0;
    end else begin
      m_q <= ctr;
      m_on <= en;
      if (en && m_on && m_q == 4'd15 && ctr == 4'd0) m_cnt <= m_cnt + 8'd1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ctr(input logic [3:0] v);
    int i = 0;
    do begin
      step(1);
      i++;
    end while (ctr !== v && i < 40);
    if (ctr !== v) begin
      n_cmp++;
      n_err++;
      $error("FAIL wait_ctr: observed %0d expected %0d", ctr, v);
    end
  endtask

  task automatic run_period(input string tag, input int exp_h);
    int h = 0, t = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      h += int'(pwm_out);
      t += int'(period_tick);
    end
    chk({tag, "_high"}, h, exp_h);
    chk({tag, "_tick"}, t, 1);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; duty_valid = 1'b0; duty_in = '0; ld = 1'b0; ld_val = '0;
    #12;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_cnt", period_cnt, 0);
    chk("rst_seq", seq_err, 0);
    chk("rst_ready", duty_ready, 1);
    #8 rstn = 1'b1;
    step(1);
    chk("no_first_wrap", period_tick, 0);
    chk("ready_idle", duty_ready, 1);
    duty_in = 4'd4; duty_valid = 1'b1;
    step(1);
    duty_valid = 1'b0;
    chk("ready_drop", duty_ready, 0);
    step(15);
    chk("first_tick", period_tick, 1);
    chk("first_cnt", period_cnt, 1);
    chk("ready_back", duty_ready, 1);
    run_period("duty4_a", 4);
    run_period("duty4_b", 4);
    chk("cnt3", period_cnt, 3);
    duty_in = 4'd0; duty_valid = 1'b1;
    step(1);
    duty_valid = 1'b0;
    chk("pend0_ready", duty_ready, 0);
    wait_ctr(4'd1);
    chk("load0_ready", duty_ready, 1);
    run_period("duty0", 0);
    duty_in = 4'd15; duty_valid = 1'b1;
    step(1);
    duty_valid = 1'b0;
    wait_ctr(4'd1);
    run_period("duty15", 15);
    duty_in = 4'd7; duty_valid = 1'b1;
    step(1);
    duty_in = 4'd2;
    step(3);
    chk("held_ready_mid", duty_ready, 0);
    wait_ctr(4'd0);
    chk("held_ready_wrap", duty_ready, 0);
    duty_valid = 1'b0;
    step(1);
    chk("held_ready_after", duty_ready, 1);
    run_period("duty7_first_only", 7);
    wait_ctr(4'd0);
    chk("coinc_ready", duty_ready, 1);
    duty_in = 4'd10; duty_valid = 1'b1;
    step(1);
    duty_valid = 1'b0;
    chk("coinc_no_pend", duty_ready, 1);
    run_period("duty10_coinc", 10);
    wait_ctr(4'd5);
    ld = 1'b1; ld_val = 4'd9;
    step(1);
    ld = 1'b0;
    chk("seq_not_yet", seq_err, 0);
    step(1);
    chk("seq_set", seq_err, 1);
    step(3);
    chk("seq_held", seq_err, 1);
    en = 1'b0;
    step(1);
    chk("seq_clr_en", seq_err, 0);
    chk("pwm_off_en", pwm_out, 0);
    chk("tick_idle", period_tick, 0);
    chk("cnt_kept_a", period_cnt, m_cnt);
    wait_ctr(4'd8);
    en = 1'b1;
    wait_ctr(4'd1);
    run_period("duty_kept", 10);
    chk("seq_ok_resync", seq_err, 0);
    step(1);
    chk("pwm_hi_pre_drop", pwm_out, 1);
    en = 1'b0;
    step(1);
    chk("pwm_drop", pwm_out, 0);
    chk("cnt_kept_b", period_cnt, m_cnt);
    en = 1'b1;
    for (int i = 0; i < 6000 && m_cnt != 8'd255; i++) step(1);
    chk("cnt_255", period_cnt, 255);
    wait_ctr(4'd1);
    chk("cnt_wrap0", period_cnt, 0);
    chk("cnt_wrap_tick", period_tick, 1);
    wait_ctr(4'd1);
    duty_in = 4'd3; duty_valid = 1'b1;
    step(1);
    duty_valid = 1'b0;
    wait_ctr(4'd6);
    chk("pre_rst_pwm", pwm_out, 1);
    chk("pre_rst_ready", duty_ready, 0);
    chk("pre_rst_cnt", period_cnt, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_pwm", pwm_out, 0);
    chk("mid_rst_tick", period_tick, 0);
    chk("mid_rst_cnt", period_cnt, 0);
    chk("mid_rst_seq", seq_err, 0);
    chk("mid_rst_ready", duty_ready, 1);
    #10 rstn = 1'b1;
    wait_ctr(4'd0);
    wait_ctr(4'd1);
    run_period("pend_discard", 0);
    chk("post_rst_cnt", period_cnt, 2);
    chk("post_rst_ready", duty_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
